pes_fnorm: RTL

PES_FNORM -- requirements
Module: pes_fnorm

---
 rtl/pes_fnorm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pes_fnorm.sv
// pes_fnorm: normalizes a signed Q2.14 product to signed Q1.7 and rounds it.
//
// The working register P is shifted left until its two top bits differ, it is
// zero, or 15 shifts have been done. The upper byte of P is then rounded half
// up using bit 7. If rounding would carry past +127, the result is clamped
// and sat_flag is set. The result is held until downstream accepts it.
//
// Ports
//   clk              clock; all state changes on the rising edge
//   reset            asynchronous, active-high reset
//   product_fraction signed Q2.14 input product
//   in_valid         product_fraction is valid this cycle
//   in_ready         high only while idle, so an input can be accepted
//   norm_fraction    signed Q1.7 normalized, rounded result
//   norm_shift       number of left shifts applied (0..15)
//   zero_flag        the input product was exactly zero
//   sat_flag         rounding overflowed and the result was clamped
//   out_valid        result outputs are valid
//   out_ready        downstream accepts the result this cycle
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready is high
// NORM  | shifting P left one bit per cycle until it is normalized
// ROUND | rounding P into the output registers
// HOLD  | result presented with out_valid, waiting for out_ready
module pes_fnorm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] product_fraction,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  norm_fraction,
    output logic [3:0]  norm_shift,
    output logic        zero_flag,
    output logic        sat_flag,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] p_q, p_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  frac_q, frac_d;
    logic [3:0]  shift_q, shift_d;
    logic        zero_q, zero_d;
    logic        sat_q, sat_d;
    logic        valid_q, valid_d;

    logic        p_is_zero;
    logic        p_normalized;
    logic [7:0]  round_sum;
    logic        round_sat;

    assign p_is_zero    = (p_q == 16'h0000);
    assign p_normalized = p_is_zero || (p_q[15] != p_q[14]) || (cnt_q == 4'hF);
    // 8-bit wrap is harmless: only 0x7F + 1 can overflow for a normalized P,
    // and that case is clamped below.
    assign round_sum    = p_q[15:8] + {7'b0, p_q[7]};
    assign round_sat    = (p_q[15:8] == 8'h7F) && p_q[7];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        frac_d  = frac_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    p_d     = product_fraction;
                    cnt_d   = 4'd0;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (p_normalized) begin
                    state_d = ST_ROUND;
                end else begin
                    p_d   = {p_q[14:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ROUND: begin
                if (p_is_zero) begin
                    frac_d = 8'h00;
                end else if (round_sat) begin
                    frac_d = 8'h7F;
                end else begin
                    frac_d = round_sum;
                end
                shift_d = p_is_zero ? 4'd0 : cnt_q;
                zero_d  = p_is_zero;
                sat_d   = round_sat;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            p_q     <= 16'h0000;
            cnt_q   <= 4'd0;
            frac_q  <= 8'h00;
            shift_q <= 4'd0;
            zero_q  <= 1'b0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            frac_q  <= frac_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign norm_fraction = frac_q;
    assign norm_shift    = shift_q;
    assign zero_flag     = zero_q;
    assign sat_flag      = sat_q;
    assign out_valid     = valid_q;

endmodule
